aes_inv_cipher: RTL and testbench

- Iterative AES inverse cipher (FIPS-197 InvCipher): decrypts one 128-bit block with a pre-expanded key schedule, one round per clock.
- Pairs with the encrypt-side iterative cipher and shares its key-schedule bus layout, so a single key-expansion block can feed both directions.
- Adds a valid/ready handshake on input and output so a controller can stream blocks through it.

---
 rtl/aes_inv_cipher.sv | 189 ++++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher
//   Iterative AES inverse cipher (FIPS-197 InvCipher). It decrypts one 128-bit
//   block per NR+2 cycles and performs one round per clock. The round keys are
//   taken from a pre-expanded key-schedule bus that uses the same layout as the
//   encrypt-side cipher.
//
// Parameters
//   NR  number of rounds (10/12/14)
//   NK  key length in 32-bit words (4/6/8); NR must equal NK+6
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset, highest priority
//   in_valid      ciphertext block presented
//   in_ready      block can be accepted (high only while idle)
//   input_bytes   ciphertext; byte 0 = [127:120], column-major state
//   ExpandedKeys  round keys; round 0 in the top 128 bits, round NR in [127:0]
//                 must stay stable from acceptance until out_valid
//   out_valid     plaintext valid, held until out_ready
//   out_ready     consumer accepts plaintext
//   out           plaintext, same byte order as input_bytes
// ---------------------------------------------------------------------------
module aes_inv_cipher #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          input_bytes,
    input  logic [128*(NR+1)-1:0] ExpandedKeys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out
);

    localparam int RW = $clog2(NR + 1);

    if (NR != NK + 6) begin : g_bad_params
        $error("aes_inv_cipher: NR must equal NK+6");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t          fsm;
    logic [127:0]  state;
    logic [RW-1:0] rnd;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial 0x11B
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map (rotl 1,3,6 xor 0x05), then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Row r of column c comes from column (c - r) mod 4 (row rotated right by r).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Round-key selection and round datapath
    // ------------------------------------------------------------------
    logic [127:0] round_key [NR+1];

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign round_key[r] = ExpandedKeys[128*(NR+1)-1-128*r -: 128];
    end

    logic [127:0] sub_shift;
    logic [127:0] keyed;
    logic [127:0] mixed;

    assign sub_shift = inv_sub_bytes(inv_shift_rows(state));
    assign keyed     = sub_shift ^ round_key[rnd];
    assign mixed     = inv_mix_columns(keyed);

    // Decoded from the FSM register only, so there is no path from in_valid.
    assign in_ready = (fsm == IDLE);

    // ------------------------------------------------------------------
    // Control FSM and state register
    // ------------------------------------------------------------------
    // NOTE: every register here is written with <= so all of them update from
    // the values present before the edge; mixing in = would create ordering bugs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state is deliberately left out of reset; it is always loaded
            // in IDLE before it is used, so resetting it would only add fan-out.
            fsm       <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            rnd       <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state <= input_bytes ^ round_key[NR];
                        rnd   <= RW'(NR - 1);
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    if (rnd != '0) begin
                        state <= mixed;
                        rnd   <= rnd - 1'b1;
                    end else begin
                        // Final round has no InvMixColumns.
                        state     <= keyed;
                        out       <= keyed;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher
//   Scoreboard bench for aes_inv_cipher at NR=10, 12 and 14. The reference
//   model is a byte-array AES encryptor with its own key expansion. Ciphertext
//   from the model is fed to the DUT, and the original plaintext is queued as
//   the expected result. A monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] din       [3];
    logic [127:0] dout      [3];
    logic [1919:0] kbus     [3];

    aes_inv_cipher #(.NR(10), .NK(4)) dut10 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .input_bytes(din[0]), .ExpandedKeys(kbus[0][1919 -: 1408]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(dout[0]));

    aes_inv_cipher #(.NR(12), .NK(6)) dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .input_bytes(din[1]), .ExpandedKeys(kbus[1][1919 -: 1664]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(dout[1]));

    aes_inv_cipher #(.NR(14), .NK(8)) dut14 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .input_bytes(din[2]), .ExpandedKeys(kbus[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(dout[2]));

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] q2[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: AES encryption on a 16-byte array
    // ------------------------------------------------------------------
    logic [7:0]   sbox [256];
    logic [127:0] rk_m [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            end
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 1; k < n; k++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    // Key occupies the top nk*32 bits of key.
    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int j = 0; j < 60; j++) begin
            if (j < nk) begin
                w[j] = key[255-32*j -: 32];
            end else begin
                t = w[j-1];
                if (j % nk == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon(j / nk), 24'h0};
                else if (nk > 6 && j % nk == 4)
                    t = sub_word(t);
                w[j] = w[j-nk] ^ t;
            end
        end
        for (int r = 0; r < 15; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_m[0][127-8*k -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_m[r][127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    function automatic logic [1919:0] pack_keys();
        logic [1919:0] p;
        for (int r = 0; r < 15; r++) p[1919-128*r -: 128] = rk_m[r];
        return p;
    endfunction

    function automatic int nr_of(input int i);
        return 10 + 2 * i;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares every accepted output against the scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        logic [127:0] e;
        bit           have;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    have = 1'b1;
                    e    = '0;
                    case (i)
                        0:       if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
                        1:       if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
                        default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
                    endcase
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output_nr%0d: got %h with no block outstanding",
                                 nr_of(i), dout[i]);
                    end else begin
                        check($sformatf("plaintext_nr%0d", nr_of(i)), dout[i], e);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_exp(input int i, input logic [127:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic set_key(input int i, input logic [255:0] key);
        expand(key, nr_of(i) - 6);
        kbus[i] = pack_keys();
    endtask

    // Presents a block and returns just after the accepting edge.
    task automatic issue(input int i, input logic [127:0] ct, output int unsigned acc);
        int n;
        din[i]      = ct;
        in_valid[i] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready[i]) break;
            n++;
            if (n > 100) break;
        end
        if (!in_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_nr%0d: block not accepted within 100 cycles", nr_of(i));
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        acc = cyc;
    endtask

    // Counts edges from just after acceptance until out_valid rises.
    task automatic wait_out(input int i, output int edges);
        edges = 0;
        while (!out_valid[i] && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid[i]) begin
            checks++;
            errors++;
            $display("FAIL output_timeout_nr%0d: out_valid not seen within 200 cycles", nr_of(i));
        end
    endtask

    task automatic run_block(input int i, input logic [255:0] key, input logic [127:0] pt,
                             input bit lat_chk);
        int unsigned acc;
        int          edges;
        set_key(i, key);
        push_exp(i, pt);
        issue(i, encrypt(pt, nr_of(i)), acc);
        wait_out(i, edges);
        if (lat_chk) check($sformatf("latency_nr%0d", nr_of(i)), 128'(edges), 128'(nr_of(i)));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input int i, input logic [255:0] key, input logic [127:0] ct,
                            input logic [127:0] pt);
        int unsigned acc;
        int          edges;
        set_key(i, key);
        push_exp(i, pt);
        issue(i, ct, acc);
        wait_out(i, edges);
        check($sformatf("fips_latency_nr%0d", nr_of(i)), 128'(edges), 128'(nr_of(i)));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] pa, pb, ca, cb;
        int unsigned  acc_a, acc_b;
        int           edges;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            din[i]       = '0;
            kbus[i]      = '0;
        end
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_flags_nr%0d", nr_of(i)),
                  128'({out_valid[i], in_ready[i]}), 128'(2'b01));
        end
        check("reset_out_nr10", dout[0], 128'h0);
        @(posedge clk);
        #1;

        // FIPS-197 known-answer vectors
        directed(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT);
        directed(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT);
        directed(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                 128'h8ea2b7ca516745bfeafc49904b496089, PT);

        // Output backpressure
        set_key(0, rand_key());
        pa = rand_blk();
        push_exp(0, pa);
        out_ready[0] = 1'b0;
        issue(0, encrypt(pa, 10), acc_a);
        wait_out(0, edges);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_out", dout[0], pa);
            check("bp_hold_flags", 128'({out_valid[0], in_ready[0]}), 128'(2'b10));
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_flags", 128'({out_valid[0], in_ready[0]}), 128'(2'b01));
        @(posedge clk);
        #1;

        // Busy input: a second block waved at the DUT during RUN is ignored
        set_key(0, rand_key());
        pa = rand_blk();
        pb = rand_blk();
        push_exp(0, pa);
        issue(0, encrypt(pa, 10), acc_a);
        for (int k = 0; k < 4; k++) begin
            din[0]      = encrypt(pb, 10);
            in_valid[0] = (k % 2 == 0);
            @(negedge clk);
            check("busy_in_ready", 128'(in_ready[0]), 128'(1'b0));
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        wait_out(0, edges);
        @(posedge clk);
        #1;

        // Back-to-back blocks with out_ready held high
        set_key(0, rand_key());
        pa = rand_blk();
        pb = rand_blk();
        ca = encrypt(pa, 10);
        cb = encrypt(pb, 10);
        push_exp(0, pa);
        push_exp(0, pb);
        issue(0, ca, acc_a);
        issue(0, cb, acc_b);
        check("b2b_accept_spacing", 128'(acc_b - acc_a), 128'd12);
        wait_out(0, edges);
        check("b2b_latency", 128'(edges), 128'd10);
        @(posedge clk);
        #1;

        // Reset in the middle of a block
        set_key(0, rand_key());
        issue(0, rand_blk(), acc_a);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_flags", 128'({out_valid[0], in_ready[0]}), 128'(2'b01));
        check("midreset_out", dout[0], 128'h0);
        @(posedge clk);
        #1;
        run_block(0, rand_key(), rand_blk(), 1'b1);

        // Random round trips
        for (int n = 0; n < 100; n++) run_block(0, rand_key(), rand_blk(), 1'b0);
        for (int n = 0; n < 10; n++) run_block(1, rand_key(), rand_blk(), 1'b0);
        for (int n = 0; n < 10; n++) run_block(2, rand_key(), rand_blk(), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty_nr10", 128'(q0.size()), 128'd0);
        check("queue_empty_nr12", 128'(q1.size()), 128'd0);
        check("queue_empty_nr14", 128'(q2.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
